// File: rtl/neo_bridge_pkg.sv
// Shared types and defaults for the FPGA<->Neo FMC port bridge.
package neo_bridge_pkg;

  localparam int PKT_W_DEF     = 11;
  localparam int NUM_PORTS_DEF = 3;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_REL  = 2'd2
  } rx_state_e;

  typedef enum logic {
    T_WAIT = 1'b0,
    T_ACK  = 1'b1
  } tx_state_e;

endpackage

// File: rtl/neo_hs_channel.sv
// One bridge port: input synchronisers, RX/TX 4-phase handshake FSMs and TX FIFO.
// Optional stall timeout enabled by NEO_BRIDGE_TIMEOUT_EN.
module neo_hs_channel
  import neo_bridge_pkg::*;
#(
  parameter int PKT_W       = PKT_W_DEF,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic [PKT_W-1:0] rx_data,
  output logic             rx_req,
  output logic [PKT_W-1:0] rx_packet,
  input  logic             rx_ack,
  input  logic             tx_req,
  input  logic [PKT_W-1:0] tx_in_data,
  output logic             tx_ack,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [PKT_W-1:0] tx_data,
  input  logic             err_clr,
  output logic             err_timeout
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] ack_sync, req_sync;
  logic                   ack_s, req_s;

  rx_state_e rx_state;
  tx_state_e tx_state;

  logic [PKT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop;
  logic             rx_to, tx_to;

  // Synchronise the chip's async handshake lines
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_sync <= '0;
      req_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], rx_ack};
      req_sync <= {req_sync[SYNC_STAGES-2:0], tx_req};
    end
  end

  assign ack_s = ack_sync[SYNC_STAGES-1];
  assign req_s = req_sync[SYNC_STAGES-1];

`ifdef NEO_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

  logic [15:0] rx_timer, tx_timer;
  logic        rx_adv, tx_adv;
  logic        err_q;

  // A handshake that completes this cycle is never counted as stalled
  assign rx_adv = ((rx_state == R_REQ) && ack_s) || ((rx_state == R_REL) && !ack_s);
  assign tx_adv = (tx_state == T_ACK) && !req_s;
  assign rx_to  = (rx_state != R_IDLE) && !rx_adv && (rx_timer == TO_LAST);
  assign tx_to  = (tx_state == T_ACK) && !tx_adv && (tx_timer == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_timer <= '0;
      tx_timer <= '0;
      err_q    <= 1'b0;
    end else begin
      rx_timer <= (rx_state == R_IDLE || rx_adv || rx_to) ? '0 : rx_timer + 16'd1;
      tx_timer <= (tx_state == T_WAIT || tx_adv || tx_to) ? '0 : tx_timer + 16'd1;
      if (rx_to || tx_to)
        err_q <= 1'b1;
      else if (err_clr)
        err_q <= 1'b0;
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_cfg;

  assign rx_to       = 1'b0;
  assign tx_to       = 1'b0;
  assign err_timeout = 1'b0;
  assign unused_cfg  = err_clr ^ (ACK_TIMEOUT != 0);
`endif

  assign rx_ready = (rx_state == R_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state  <= R_IDLE;
      rx_req    <= 1'b0;
      rx_packet <= '0;
    end else begin
      unique case (rx_state)
        R_IDLE: begin
          if (rx_valid) begin
            rx_packet <= rx_data;
            rx_req    <= 1'b1;
            rx_state  <= R_REQ;
          end
        end
        R_REQ: begin
          if (rx_to) begin
            rx_req   <= 1'b0;
            rx_state <= R_IDLE;
          end else if (ack_s) begin
            rx_req   <= 1'b0;
            rx_state <= R_REL;
          end
        end
        R_REL: begin
          if (rx_to || !ack_s)
            rx_state <= R_IDLE;
        end
        default: begin
          rx_req   <= 1'b0;
          rx_state <= R_IDLE;
        end
      endcase
    end
  end

  // Full check uses the registered count, so a same-cycle pop never frees a slot early
  assign push     = (tx_state == T_WAIT) && req_s && (count != FULL_CNT);
  assign tx_valid = (count != '0);
  assign pop      = tx_valid && tx_ready;
  assign tx_data  = tx_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= T_WAIT;
      tx_ack   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      unique case (tx_state)
        T_WAIT: begin
          if (push) begin
            tx_ack   <= 1'b1;
            tx_state <= T_ACK;
          end
        end
        T_ACK: begin
          if (tx_to || !req_s) begin
            tx_ack   <= 1'b0;
            tx_state <= T_WAIT;
          end
        end
        default: begin
          tx_ack   <= 1'b0;
          tx_state <= T_WAIT;
        end
      endcase
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  // Storage is data-only; emptiness is tracked by count
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= tx_in_data;
  end

endmodule

// File: rtl/neo_fmc_port_bridge.sv
// FPGA<->Neo FMC bridge: NUM_PORTS independent handshake channels.
// Optional handshake timeout enabled by NEO_BRIDGE_TIMEOUT_EN.
module neo_fmc_port_bridge
  import neo_bridge_pkg::*;
#(
  parameter int NUM_PORTS   = NUM_PORTS_DEF,
  parameter int PKT_W       = PKT_W_DEF,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic                            fmc_out_clk,
  output logic                            fmc_out_rst,
  input  logic [NUM_PORTS-1:0]            rx_valid,
  output logic [NUM_PORTS-1:0]            rx_ready,
  input  logic [NUM_PORTS-1:0][PKT_W-1:0] rx_data,
  output logic [NUM_PORTS-1:0]            fmc_out_rx_req,
  output logic [NUM_PORTS-1:0][PKT_W-1:0] fmc_out_rx_packet,
  input  logic [NUM_PORTS-1:0]            fmc_in_rx_ack,
  input  logic [NUM_PORTS-1:0]            fmc_in_tx_req,
  input  logic [NUM_PORTS-1:0][PKT_W-1:0] fmc_in_tx_data,
  output logic [NUM_PORTS-1:0]            fmc_out_tx_ack,
  output logic [NUM_PORTS-1:0]            tx_valid,
  input  logic [NUM_PORTS-1:0]            tx_ready,
  output logic [NUM_PORTS-1:0][PKT_W-1:0] tx_data,
  input  logic                            err_clr,
  output logic [NUM_PORTS-1:0]            err_timeout
);

  assign fmc_out_clk = clk;
  assign fmc_out_rst = rst;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    neo_hs_channel #(
      .PKT_W       (PKT_W),
      .FIFO_DEPTH  (FIFO_DEPTH),
      .SYNC_STAGES (SYNC_STAGES),
      .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .rx_valid    (rx_valid[p]),
      .rx_ready    (rx_ready[p]),
      .rx_data     (rx_data[p]),
      .rx_req      (fmc_out_rx_req[p]),
      .rx_packet   (fmc_out_rx_packet[p]),
      .rx_ack      (fmc_in_rx_ack[p]),
      .tx_req      (fmc_in_tx_req[p]),
      .tx_in_data  (fmc_in_tx_data[p]),
      .tx_ack      (fmc_out_tx_ack[p]),
      .tx_valid    (tx_valid[p]),
      .tx_ready    (tx_ready[p]),
      .tx_data     (tx_data[p]),
      .err_clr     (err_clr),
      .err_timeout (err_timeout[p])
    );
  end

endmodule
